// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified I/D memory between the fetch (if_*) and data (dm_*) ports.
// Ports: clk1/rst (async, active-high); if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//        dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata;
//        mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory; busy = transaction in flight.
// Optional: define MEM_ARB_PERF_EN to add perf_if_gnt/perf_dm_gnt/perf_conflict counters.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_if_gnt,
    output logic [31:0]   perf_dm_gnt,
    output logic [31:0]   perf_conflict
`endif
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          if_gnt_q, if_gnt_d;
    logic          dm_gnt_q, dm_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          dm_rvalid_q, dm_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          streak_max, dm_win, if_win;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_gnt_q, perf_if_gnt_d;
    logic [31:0]   perf_dm_gnt_q, perf_dm_gnt_d;
    logic [31:0]   perf_conflict_q, perf_conflict_d;
`endif

    assign streak_max = streak_q == SW'(MAX_STREAK);
    // Data port wins unless fetch has been waiting through a full streak.
    assign dm_win     = dm_req && !(if_req && streak_max);
    assign if_win     = if_req && !dm_win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        lat_cnt_d   = lat_cnt_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        mem_en_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_PERF_EN
        perf_if_gnt_d   = perf_if_gnt_q;
        perf_dm_gnt_d   = perf_dm_gnt_q;
        perf_conflict_d = perf_conflict_q;
`endif
        if (state_q == S_IDLE) begin
            if (dm_win || if_win) begin
                state_d     = S_WAIT;
                owner_d     = dm_win;
                lat_cnt_d   = LW'(MEM_LAT);
                if_gnt_d    = if_win;
                dm_gnt_d    = dm_win;
                mem_en_d    = 1'b1;
                mem_we_d    = dm_win && dm_we;
                mem_addr_d  = dm_win ? dm_addr : if_addr;
                mem_wdata_d = dm_win ? dm_wdata : mem_wdata_q;
                streak_d    = (dm_win && if_req) ? (streak_max ? streak_q : streak_q + SW'(1)) : '0;
`ifdef MEM_ARB_PERF_EN
                perf_if_gnt_d   = perf_if_gnt_q + 32'(if_win);
                perf_dm_gnt_d   = perf_dm_gnt_q + 32'(dm_win);
                perf_conflict_d = perf_conflict_q + 32'(if_req && dm_req);
`endif
            end
        end else if (!mem_en_q) begin
            // The first WAIT edge is the one where the memory samples mem_en, so
            // the latency count starts on the edge after it.
            lat_cnt_d = lat_cnt_q - LW'(1);
            if (lat_cnt_q == LW'(1)) begin
                state_d     = S_IDLE;
                if_rvalid_d = !owner_q;
                dm_rvalid_d = owner_q;
                if_rdata_d  = owner_q ? if_rdata_q : mem_rdata;
                dm_rdata_d  = (owner_q && !mem_we_q) ? mem_rdata : dm_rdata_q;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            streak_q    <= '0;
            lat_cnt_q   <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            lat_cnt_q   <= lat_cnt_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            perf_if_gnt_q   <= '0;
            perf_dm_gnt_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_if_gnt_q   <= perf_if_gnt_d;
            perf_dm_gnt_q   <= perf_dm_gnt_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_if_gnt   = perf_if_gnt_q;
    assign perf_dm_gnt   = perf_dm_gnt_q;
    assign perf_conflict = perf_conflict_q;
`endif

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = state_q == S_WAIT;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_gnt, perf_dm_gnt, perf_conflict;
`endif

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_STREAK(4)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_gnt(perf_if_gnt), .perf_dm_gnt(perf_dm_gnt), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk1 = ~clk1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a == AW'(5)) ? 32'h00628BB3 : {16'hC0DE, 6'h0, a};
    endfunction

    // Behavioural memory: samples mem_en at an edge, data valid one edge later.
    logic [DW-1:0] mem [0:1023];
    bit            mem_wr [0:1023];
    always @(posedge clk1) begin
        if (mem_en) begin
            mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
            if (mem_we) begin
                mem[mem_addr]    <= mem_wdata;
                mem_wr[mem_addr] <= 1'b1;
            end
        end
    end

    // Bench-side reference contents, updated when stores are issued.
    logic [DW-1:0] ref_mem [0:1023];
    bit            ref_wr [0:1023];
    logic [DW-1:0] last_dm = '0;
    logic [DW:0]   sb [$];

    function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic txn(input bit is_dm, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic        got;
        logic [DW:0] e;
        sb.push_back({is_dm, (is_dm && we) ? last_dm : ref_word(a)});
        if (is_dm && we) begin
            ref_mem[a] = wd;
            ref_wr[a]  = 1'b1;
        end
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = is_dm ? dm_gnt : if_gnt;
        end
        chk("txn_gnt", 64'(got), 64'd1);
        chk("txn_mem_en", 64'(mem_en), 64'd1);
        chk("txn_mem_we", 64'(mem_we), 64'(is_dm && we));
        chk("txn_mem_addr", 64'(mem_addr), 64'(a));
        if (is_dm && we) chk("txn_mem_wdata", 64'(mem_wdata), 64'(wd));
        if_req = 1'b0;
        dm_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = dm_rvalid || if_rvalid;
        end
        chk("txn_rvalid", 64'(got), 64'd1);
        e = sb.pop_front();
        chk("txn_owner", 64'(dm_rvalid), 64'(e[DW]));
        chk("txn_rdata", 64'(e[DW] ? dm_rdata : if_rdata), 64'(e[DW-1:0]));
        if (e[DW]) last_dm = e[DW-1:0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] order;
        int         n;
        logic       seen;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] p_if, p_dm, p_cf;
`endif
        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_gnts", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        rst = 1'b0;
        tick();

        // Fetch only: exact cycle timing
        if_req = 1'b1; if_addr = 10'd5;
        tick();
        chk("f_gnt_e0", 64'(if_gnt), 64'd1);
        chk("f_mem_en_e0", 64'(mem_en), 64'd1);
        chk("f_mem_addr", 64'(mem_addr), 64'd5);
        chk("f_mem_we", 64'(mem_we), 64'd0);
        chk("f_busy_e0", 64'(busy), 64'd1);
        if_req = 1'b0;
        tick();
        chk("f_gnt_e1", 64'({if_gnt, mem_en, if_rvalid}), 64'd0);
        chk("f_busy_e1", 64'(busy), 64'd1);
        tick();
        chk("f_rvalid_e2", 64'(if_rvalid), 64'd1);
        chk("f_rdata_e2", 64'(if_rdata), 64'h00628BB3);
        chk("f_busy_e2", 64'(busy), 64'd0);
        tick();
        chk("f_rvalid_e3", 64'(if_rvalid), 64'd0);
        chk("f_rdata_hold", 64'(if_rdata), 64'h00628BB3);

        // Store then load of the same word
        txn(1'b1, 1'b1, 10'd19, 32'd15);
        txn(1'b1, 1'b0, 10'd19, 32'd0);
        chk("ld_after_st", 64'(dm_rdata), 64'd15);

        // Simultaneous requests, streak 0: dm first, fetch right after
        if_req = 1'b1; if_addr = 10'd7;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd8;
        tick();
        chk("sim_dm_gnt", 64'({dm_gnt, if_gnt}), 64'b10);
        dm_req = 1'b0;
        tick();
        chk("sim_if_gnt_e1", 64'(if_gnt), 64'd0);
        tick();
        chk("sim_dm_rvalid", 64'(dm_rvalid), 64'd1);
        chk("sim_dm_rdata", 64'(dm_rdata), 64'(ref_word(10'd8)));
        chk("sim_if_gnt_e2", 64'(if_gnt), 64'd0);
        tick();
        chk("sim_if_gnt_e3", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        tick();
        tick();
        chk("sim_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("sim_if_rdata", 64'(if_rdata), 64'(ref_word(10'd7)));
        tick();

        // Both requests held: streak limit
`ifdef MEM_ARB_PERF_EN
        p_if = perf_if_gnt; p_dm = perf_dm_gnt; p_cf = perf_conflict;
`endif
        order = '0;
        n = 0;
        if_req = 1'b1; if_addr = 10'd7;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd8;
        for (int c = 0; c < 80 && n < 10; c++) begin
            tick();
            if (if_rvalid) chk("st_if_rdata", 64'(if_rdata), 64'(ref_word(10'd7)));
            if (dm_rvalid) chk("st_dm_rdata", 64'(dm_rdata), 64'(ref_word(10'd8)));
            if (dm_gnt || if_gnt) begin
                order[n] = dm_gnt;
                n++;
                if (n == 10) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        chk("st_grants", 64'(n), 64'd10);
        chk("st_order", 64'(order), 64'b0111101111);
        for (int c = 0; c < 4; c++) tick();
`ifdef MEM_ARB_PERF_EN
        chk("perf_dm", 64'(perf_dm_gnt - p_dm), 64'd8);
        chk("perf_if", 64'(perf_if_gnt - p_if), 64'd2);
        chk("perf_cf", 64'(perf_conflict - p_cf), 64'd10);
`endif

        // Reset during WAIT aborts the transaction
        if_req = 1'b1; if_addr = 10'd9;
        tick();
        chk("ra_gnt", 64'(if_gnt), 64'd1);
        if_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("ra_outs", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}), 64'd0);
        chk("ra_addr", 64'(mem_addr), 64'd0);
        chk("ra_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
`ifdef MEM_ARB_PERF_EN
        chk("ra_perf", 64'({perf_if_gnt, perf_dm_gnt}), 64'd0);
`endif
        tick();
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen = seen | if_rvalid | dm_rvalid | busy;
        end
        chk("ra_no_rvalid", 64'(seen), 64'd0);
        last_dm = '0;
        txn(1'b0, 1'b0, 10'd9, 32'd0);
        txn(1'b1, 1'b0, 10'd1023, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
